// File: rtl/t07_wb_mem_responder_if.sv
// Wishbone classic subordinate bus bundle for t07_wb_mem_responder.
// Signal names keep the original port names so existing connections map one-to-one.
interface t07_wb_mem_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o
  );
endinterface

// File: rtl/t07_wb_mem_responder.sv
// Wishbone classic subordinate backed by a DEPTH_WORDS x 32 register array,
// with programmable wait states and err termination outside the mapped window.
module t07_wb_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  t07_wb_mem_responder_if.slave   wbs
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      stateNext;
  logic [2:0]  waitCnt;

  logic        weQ;
  logic [31:0] adrQ;
  logic [31:0] datQ;
  logic [3:0]  selQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic        ackQ;
  logic        errQ;
  logic [31:0] rdatQ;

  logic        ackNext;
  logic        errNext;
  logic [31:0] datNext;
  logic        wrEn;

  logic          inRange;
  logic [AW-1:0] idx;
  logic [31:0]   mask;

  wire reqValid = wbs.wbs_cyc_i & wbs.wbs_stb_i;

  assign inRange = ({1'b0, adrQ} >= {1'b0, BASE_ADDR}) && ({1'b0, adrQ} < LIMIT);
  assign idx     = AW'((adrQ - BASE_ADDR) >> 2);
  assign mask    = {{8{selQ[3]}}, {8{selQ[2]}}, {8{selQ[1]}}, {8{selQ[0]}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE)
        waitCnt <= WAIT_LOAD;
      else if (state == WAIT && waitCnt != '0)
        waitCnt <= waitCnt - 3'd1;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (reqValid) stateNext = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: begin
        if (!wbs.wbs_cyc_i)    stateNext = IDLE;
        else if (waitCnt == '0) stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Termination is decided here and registered below, so ack/err/dat appear
  // in the cycle after the RESP edge and the array write lands on that edge.
  always_comb begin
    ackNext = '0;
    errNext = '0;
    datNext = '0;
    wrEn    = '0;
    if (state == RESP) begin
      if (inRange) begin
        ackNext = 1'b1;
        wrEn    = weQ;
        if (!weQ) datNext = mem[idx] & mask;
      end else begin
        errNext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weQ  <= '0;
      adrQ <= '0;
      datQ <= '0;
      selQ <= '0;
    end else if (state == IDLE && reqValid) begin
      weQ  <= wbs.wbs_we_i;
      adrQ <= wbs.wbs_adr_i;
      datQ <= wbs.wbs_dat_i;
      selQ <= wbs.wbs_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ackQ  <= '0;
      errQ  <= '0;
      rdatQ <= '0;
      mem   <= '{default: '0};
    end else begin
      ackQ  <= ackNext;
      errQ  <= errNext;
      rdatQ <= datNext;
      if (wrEn) mem[idx] <= (mem[idx] & ~mask) | (datQ & mask);
    end
  end

  assign wbs.wbs_ack_o = ackQ;
  assign wbs.wbs_err_o = errQ;
  assign wbs.wbs_dat_o = rdatQ;

endmodule
